apb_master_arbiter: RTL and testbench

Two-port APB master that shares one APB bus between two requesters: port 0 (AHB-to-APB bridge path) and port 1 (configuration/DMA master). The block arbitrates round-robin, sequences the APB SETUP and ACCESS phases, honours Pready wait states, and returns read data and error status to the granted requester with a one-cycle done pulse. It sits between the requesters and the peripheral-select fabric, driving the same Paddr/Pwdata/Pwrite/Pselx/Penable signal set the peripherals already decode.

---
 rtl/apb_master_arbiter_if.sv | 51 +++++
 rtl/apb_master_arbiter.sv | 110 +++++++++++
 tb/tb_apb_master_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
// Bus bundle for apb_master_arbiter: two requester ports plus the shared APB signal set.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [2:0]        req0_sel;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_err;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [2:0]        req1_sel;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_err;

  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Pwrite;
  logic [2:0]        Pselx;
  logic              Penable;
  logic              Pready;
  logic [DATA_W-1:0] Prdata;
  logic              Pslverr;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_sel,
    output req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_sel,
    output req1_done, req1_rdata, req1_err,
    output Paddr, Pwdata, Pwrite, Pselx, Penable,
    input  Pready, Prdata, Pslverr
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_sel,
    input  req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_sel,
    input  req1_done, req1_rdata, req1_err,
    input  Paddr, Pwdata, Pwrite, Pselx, Penable,
    output Pready, Prdata, Pslverr
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-port round-robin APB master: arbitrates, runs SETUP/ACCESS with Pready waits, returns done/rdata/err.
// Optional ACCESS wait-state timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  apb_master_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic [2:0]        sel_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              err0_q, err1_q;
  logic              any_valid, pick, timeout_hit;
  logic [2:0]        pick_sel;
  logic [DATA_W-1:0] cap_rdata;
  logic              cap_err;

  // On a tie the port not granted last wins; otherwise whichever port is valid.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    pick      = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    pick_sel  = pick ? bus.req1_sel : bus.req0_sel;
    cap_rdata = (bus.Pready && !bus.Pwrite && !bus.Pslverr) ? bus.Prdata : '0;
    cap_err   = bus.Pready ? bus.Pslverr : 1'b1;
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] tcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 tcnt <= '0;
    else if (state != ACCESS) tcnt <= '0;
    else if (!bus.Pready)     tcnt <= tcnt + 8'd1;
  end

  // tcnt counts completed wait cycles, so the limit cycle is the one seeing TIMEOUT_CYC-1.
  assign timeout_hit = (tcnt == 8'(TIMEOUT_CYC - 1)) && !bus.Pready;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = (pick_sel == 3'b000) ? DONE : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.Pready || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.Pselx     = (state == SETUP || state == ACCESS) ? sel_q : '0;
    bus.Penable   = (state == ACCESS);
    bus.req0_done = (state == DONE) && !last_grant;
    bus.req1_done = (state == DONE) && last_grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      sel_q      <= '0;
      bus.Paddr  <= '0;
      bus.Pwdata <= '0;
      bus.Pwrite <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          last_grant <= pick;
          sel_q      <= pick_sel;
          bus.Paddr  <= pick ? bus.req1_addr  : bus.req0_addr;
          bus.Pwdata <= pick ? bus.req1_wdata : bus.req0_wdata;
          bus.Pwrite <= pick ? bus.req1_write : bus.req0_write;
          if (pick_sel == 3'b000) begin
            if (pick) begin rdata1_q <= '0; err1_q <= 1'b1; end
            else      begin rdata0_q <= '0; err0_q <= 1'b1; end
          end
        end
        ACCESS: if (bus.Pready || timeout_hit) begin
          if (last_grant) begin rdata1_q <= cap_rdata; err1_q <= cap_err; end
          else            begin rdata0_q <= cap_rdata; err0_q <= cap_err; end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_rdata = rdata0_q;
  assign bus.req0_err   = err0_q;
  assign bus.req1_rdata = rdata1_q;
  assign bus.req1_err   = err1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter; timeout scenarios run when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [136:0] outs_vec();
    return {bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Pselx, bus.Penable,
            bus.req0_done, bus.req0_rdata, bus.req0_err,
            bus.req1_done, bus.req1_rdata, bus.req1_err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_sel = '0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_sel = '0;
    bus.Pready = 1; bus.Prdata = '0; bus.Pslverr = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req0_valid = 1; bus.req0_sel = 3'b001; bus.req0_addr = 32'h44;
    repeat (3) cyc();
    checks++; if (outs_vec() !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs_vec()); end
    bus.req0_valid = 0;
    rst = 1;
    cyc();
    checks++; if (bus.Pselx !== 3'b000) begin errors++; $display("FAIL reset_idle_psel: got %b want 000", bus.Pselx); end
  endtask

  task automatic test_write_zero_wait();
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 32'h0000_0010;
    bus.req0_wdata = 32'hA5A5_A5A5; bus.req0_sel = 3'b001; bus.Pready = 1;
    cyc();
    checks++; if ({bus.Pselx, bus.Penable} !== 4'b0010) begin errors++; $display("FAIL wr_setup: got psel/en %b want 0010", {bus.Pselx, bus.Penable}); end
    checks++; if ({bus.Paddr, bus.Pwdata, bus.Pwrite} !== {32'h10, 32'hA5A5_A5A5, 1'b1}) begin errors++; $display("FAIL wr_setup_fields: got %h %h %b", bus.Paddr, bus.Pwdata, bus.Pwrite); end
    cyc();
    checks++; if ({bus.Pselx, bus.Penable, bus.req0_done} !== 5'b00110) begin errors++; $display("FAIL wr_access: got psel/en/done %b want 00110", {bus.Pselx, bus.Penable, bus.req0_done}); end
    cyc();
    checks++; if ({bus.req0_done, bus.req0_err, bus.req1_done, bus.Pselx, bus.Penable} !== 7'b1000000) begin errors++; $display("FAIL wr_done: got done0/err0/done1/psel/en %b want 1000000", {bus.req0_done, bus.req0_err, bus.req1_done, bus.Pselx, bus.Penable}); end
    checks++; if (bus.req0_rdata !== '0) begin errors++; $display("FAIL wr_rdata_zero: got %h want 0", bus.req0_rdata); end
    bus.req0_valid = 0;
    cyc();
    checks++; if (bus.req0_done !== 1'b0) begin errors++; $display("FAIL wr_done_one_cycle: got %b want 0", bus.req0_done); end
  endtask

  task automatic test_read_wait();
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 32'h20; bus.req1_sel = 3'b010;
    bus.Pready = 0; bus.Prdata = 32'hBAD0_BAD0;
    cyc();
    checks++; if ({bus.Pselx, bus.Penable, bus.Pwrite} !== 5'b01000) begin errors++; $display("FAIL rd_setup: got psel/en/wr %b want 01000", {bus.Pselx, bus.Penable, bus.Pwrite}); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++; if ({bus.Pselx, bus.Penable, bus.req1_done} !== 5'b01010) begin errors++; $display("FAIL rd_access_%0d: got psel/en/done %b want 01010", k, {bus.Pselx, bus.Penable, bus.req1_done}); end
      if (k == 3) begin bus.Pready = 1; bus.Prdata = 32'h1234_5678; end
    end
    cyc();
    checks++; if ({bus.req1_done, bus.req1_err, bus.req0_done} !== 3'b100) begin errors++; $display("FAIL rd_done: got done1/err1/done0 %b want 100", {bus.req1_done, bus.req1_err, bus.req0_done}); end
    checks++; if (bus.req1_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata: got %h want 12345678", bus.req1_rdata); end
    bus.req1_valid = 0; bus.Prdata = '0;
    cyc();
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int last_cyc = 0;
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 32'h100; bus.req0_wdata = 32'h0; bus.req0_sel = 3'b001;
    bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 32'h200; bus.req1_wdata = 32'h1; bus.req1_sel = 3'b100;
    bus.Pready = 1;
    for (int c = 1; c <= 40 && n_done < 4; c++) begin
      cyc();
      checks++; if (bus.req0_done && bus.req1_done) begin errors++; $display("FAIL rr_overlap: both done high at cycle %0d", c); end
      if (bus.Pselx != 3'b000 && !bus.Penable) begin
        checks++; if (bus.Paddr !== ((n_done % 2 == 0) ? 32'h100 : 32'h200)) begin errors++; $display("FAIL rr_setup_addr_%0d: got %h", n_done, bus.Paddr); end
      end
      if (bus.req0_done || bus.req1_done) begin
        checks++; if (bus.req1_done !== ((n_done % 2) == 1)) begin errors++; $display("FAIL rr_order_%0d: got port %0d want %0d", n_done, bus.req1_done, n_done % 2); end
        checks++; if ((c - last_cyc) !== ((n_done == 0) ? 3 : 4)) begin errors++; $display("FAIL rr_spacing_%0d: got %0d want %0d", n_done, c - last_cyc, (n_done == 0) ? 3 : 4); end
        last_cyc = c;
        n_done++;
        if (n_done == 4) begin bus.req0_valid = 0; bus.req1_valid = 0; end
      end
    end
    checks++; if (n_done !== 4) begin errors++; $display("FAIL rr_count: got %0d done pulses want 4", n_done); end
    cyc();
  endtask

  task automatic test_unmapped();
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h30; bus.req0_sel = 3'b001;
    bus.Pready = 1; bus.Prdata = 32'hCAFE_F00D;
    repeat (3) cyc();
    checks++; if ({bus.req0_done, bus.req0_rdata} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL pre_read: got done %b rdata %h want 1 cafef00d", bus.req0_done, bus.req0_rdata); end
    bus.req0_valid = 0; bus.Prdata = '0;
    cyc();
    bus.req0_valid = 1; bus.req0_addr = 32'h40; bus.req0_sel = 3'b000;
    cyc();
    checks++; if ({bus.req0_done, bus.req0_err, bus.Pselx, bus.Penable} !== 6'b110000) begin errors++; $display("FAIL unmap_done: got done/err/psel/en %b want 110000", {bus.req0_done, bus.req0_err, bus.Pselx, bus.Penable}); end
    checks++; if (bus.req0_rdata !== '0) begin errors++; $display("FAIL unmap_rdata: got %h want 0", bus.req0_rdata); end
    bus.req0_valid = 0;
    cyc();
    checks++; if ({bus.req0_done, bus.Pselx, bus.Penable} !== 5'b00000) begin errors++; $display("FAIL unmap_after: got done/psel/en %b want 00000", {bus.req0_done, bus.Pselx, bus.Penable}); end
  endtask

  task automatic test_slverr();
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h50; bus.req0_sel = 3'b011;
    bus.Pready = 1; bus.Pslverr = 1; bus.Prdata = 32'hDEAD_BEEF;
    repeat (3) cyc();
    checks++; if ({bus.req0_done, bus.req0_err, bus.req0_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL slverr: got done %b err %b rdata %h want 1 1 0", bus.req0_done, bus.req0_err, bus.req0_rdata); end
    bus.req0_valid = 0; bus.Pslverr = 0; bus.Prdata = '0;
    cyc();
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 32'h60; bus.req1_sel = 3'b001;
    bus.Pready = 0; bus.Prdata = 32'h7777_7777;
    cyc();
    for (int k = 0; k < TO; k++) begin
      cyc();
      checks++; if (bus.Penable !== 1'b1) begin errors++; $display("FAIL to_access_%0d: got en %b want 1", k, bus.Penable); end
    end
    cyc();
    checks++; if ({bus.req1_done, bus.req1_err, bus.Pselx, bus.Penable} !== 6'b110000) begin errors++; $display("FAIL to_done: got done/err/psel/en %b want 110000", {bus.req1_done, bus.req1_err, bus.Pselx, bus.Penable}); end
    checks++; if (bus.req1_rdata !== '0) begin errors++; $display("FAIL to_rdata: got %h want 0", bus.req1_rdata); end
    bus.req1_valid = 0;
    cyc();
    bus.req1_valid = 1;
    cyc();
    for (int k = 0; k < TO; k++) begin
      cyc();
      if (k == TO - 1) begin bus.Pready = 1; bus.Prdata = 32'h0BAD_F00D; end
    end
    cyc();
    checks++; if ({bus.req1_done, bus.req1_err, bus.req1_rdata} !== {2'b10, 32'h0BAD_F00D}) begin errors++; $display("FAIL to_limit_ready: got done %b err %b rdata %h want 1 0 0badf00d", bus.req1_done, bus.req1_err, bus.req1_rdata); end
    bus.req1_valid = 0; bus.Prdata = '0;
    cyc();
  endtask
`endif

  task automatic test_reset_mid();
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 32'h70; bus.req0_wdata = 32'h5A5A_5A5A; bus.req0_sel = 3'b001;
    bus.Pready = 0;
    cyc();
    cyc();
    checks++; if (bus.Penable !== 1'b1) begin errors++; $display("FAIL rstmid_in_access: got en %b want 1", bus.Penable); end
    rst = 0;
    #1;
    checks++; if (outs_vec() !== '0) begin errors++; $display("FAIL rstmid_immediate: got %h want 0", outs_vec()); end
    bus.req0_valid = 0; bus.Pready = 1;
    cyc();
    cyc();
    checks++; if (outs_vec() !== '0) begin errors++; $display("FAIL rstmid_held: got %h want 0", outs_vec()); end
    rst = 1;
    cyc();
    checks++; if (bus.req0_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b want 0", bus.req0_done); end
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 32'h80; bus.req1_sel = 3'b010; bus.Prdata = 32'h600D_CAFE;
    cyc();
    checks++; if ({bus.Pselx, bus.Penable, bus.Paddr} !== {4'b0100, 32'h80}) begin errors++; $display("FAIL rstmid_setup: got psel %b en %b addr %h", bus.Pselx, bus.Penable, bus.Paddr); end
    cyc();
    cyc();
    checks++; if ({bus.req1_done, bus.req1_err, bus.req1_rdata} !== {2'b10, 32'h600D_CAFE}) begin errors++; $display("FAIL rstmid_next: got done %b err %b rdata %h want 1 0 600dcafe", bus.req1_done, bus.req1_err, bus.req1_rdata); end
    bus.req1_valid = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_back_to_back();
    test_unmapped();
    test_slverr();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
